// File: rtl/id_pipe_stage.sv
// id_pipe_stage: single-entry registered decode stage for a small RV integer
// subset (OP-IMM, OP, LUI, AUIPC) with a valid/ready handshake, a flush that
// discards the held and incoming instruction, and a saturating illegal counter.
module id_pipe_stage #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       inst,
   input  logic [XLEN-1:0]   pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ra_en,
   output logic              rb_en,
   output logic              rd_en,
   output logic [REG_AW-1:0] ra_addr,
   output logic [REG_AW-1:0] rb_addr,
   output logic [REG_AW-1:0] rd_addr,
   output logic [XLEN-1:0]   imm,
   output logic [XLEN-1:0]   out_pc,
   output logic              alu_bsrc,
   output logic              alu_apc,
   output logic [3:0]        alu_ctl,
   output logic              illegal,
   output logic [CNT_W-1:0]  ill_cnt
);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic             accept;

   logic             d_legal;
   logic             d_ra_en;
   logic             d_rb_en;
   logic             d_bsrc;
   logic             d_apc;
   logic [3:0]       d_ctl;
   logic [XLEN-1:0]  d_imm;
   logic [XLEN-1:0]  imm_i;
   logic [XLEN-1:0]  imm_u;
   logic [XLEN-1:0]  imm_sh;
   logic             sh_lo_ok;
   logic             sh_hi_ok;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   // Stage can take a new instruction whenever its slot is empty or draining.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // Immediate formats; shamt width and the upper shift-field check follow XLEN.
   always_comb begin
      imm_i = XLEN'($signed(inst[31:20]));
      imm_u = XLEN'($signed({inst[31:12], 12'b0}));
      if (XLEN == 64) begin
         imm_sh   = XLEN'(inst[25:20]);
         sh_lo_ok = (inst[31:26] == 6'b000000);
         sh_hi_ok = (inst[31:26] == 6'b010000);
      end else begin
         imm_sh   = XLEN'(inst[24:20]);
         sh_lo_ok = (funct7 == 7'b0000000);
         sh_hi_ok = (funct7 == 7'b0100000);
      end
   end

   // Decode of the incoming instruction; anything unmatched stays illegal.
   always_comb begin
      d_legal = 1'b0;
      d_ra_en = 1'b0;
      d_rb_en = 1'b0;
      d_bsrc  = 1'b0;
      d_apc   = 1'b0;
      d_ctl   = 4'b0000;
      d_imm   = '0;
      unique case (opcode)
         OPC_OP_IMM: begin
            if (funct3 == 3'b001) begin
               if (sh_lo_ok) begin
                  d_legal = 1'b1;
                  d_ctl   = 4'b0001;
                  d_imm   = imm_sh;
               end
            end else if (funct3 == 3'b101) begin
               if (sh_lo_ok || sh_hi_ok) begin
                  d_legal = 1'b1;
                  d_ctl   = {sh_hi_ok, funct3};
                  d_imm   = imm_sh;
               end
            end else begin
               d_legal = 1'b1;
               d_ctl   = {1'b0, funct3};
               d_imm   = imm_i;
            end
            if (d_legal) begin
               d_ra_en = 1'b1;
               d_bsrc  = 1'b1;
            end
         end
         OPC_OP: begin
            if (funct7 == 7'b0000000) begin
               d_legal = 1'b1;
               d_ctl   = {1'b0, funct3};
            end else if (funct7 == 7'b0100000 &&
                         (funct3 == 3'b000 || funct3 == 3'b101)) begin
               d_legal = 1'b1;
               d_ctl   = {1'b1, funct3};
            end
            if (d_legal) begin
               d_ra_en = 1'b1;
               d_rb_en = 1'b1;
            end
         end
         OPC_LUI: begin
            d_legal = 1'b1;
            d_bsrc  = 1'b1;
            d_ctl   = 4'b1111;
            d_imm   = imm_u;
         end
         OPC_AUIPC: begin
            d_legal = 1'b1;
            d_bsrc  = 1'b1;
            d_apc   = 1'b1;
            d_imm   = imm_u;
         end
         default: begin
            d_legal = 1'b0;
         end
      endcase
   end

   // Output slot: reset clears, flush empties, accept loads, drain empties.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         ra_en     <= 1'b0;
         rb_en     <= 1'b0;
         rd_en     <= 1'b0;
         ra_addr   <= '0;
         rb_addr   <= '0;
         rd_addr   <= '0;
         imm       <= '0;
         out_pc    <= '0;
         alu_bsrc  <= 1'b0;
         alu_apc   <= 1'b0;
         alu_ctl   <= 4'b0000;
         illegal   <= 1'b0;
         ill_cnt   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         ra_en     <= d_ra_en;
         rb_en     <= d_rb_en;
         rd_en     <= d_legal && (inst[11:7] != 5'd0);
         ra_addr   <= REG_AW'(inst[19:15]);
         rb_addr   <= REG_AW'(inst[24:20]);
         rd_addr   <= REG_AW'(inst[11:7]);
         imm       <= d_imm;
         out_pc    <= pc;
         alu_bsrc  <= d_bsrc;
         alu_apc   <= d_apc;
         alu_ctl   <= d_ctl;
         illegal   <= !d_legal;
         if (!d_legal && ill_cnt != '1) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage (XLEN=64) with hand-computed expectations.
module tb_id_pipe_stage;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 16;

   logic              clock;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       inst;
   logic [XLEN-1:0]   pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic              ra_en;
   logic              rb_en;
   logic              rd_en;
   logic [REG_AW-1:0] ra_addr;
   logic [REG_AW-1:0] rb_addr;
   logic [REG_AW-1:0] rd_addr;
   logic [XLEN-1:0]   imm;
   logic [XLEN-1:0]   out_pc;
   logic              alu_bsrc;
   logic              alu_apc;
   logic [3:0]        alu_ctl;
   logic              illegal;
   logic [CNT_W-1:0]  ill_cnt;

   int n_pass;
   int n_total;

   id_pipe_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inst      (inst),
      .pc        (pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ra_en     (ra_en),
      .rb_en     (rb_en),
      .rd_en     (rd_en),
      .ra_addr   (ra_addr),
      .rb_addr   (rb_addr),
      .rd_addr   (rd_addr),
      .imm       (imm),
      .out_pc    (out_pc),
      .alu_bsrc  (alu_bsrc),
      .alu_apc   (alu_apc),
      .alu_ctl   (alu_ctl),
      .illegal   (illegal),
      .ill_cnt   (ill_cnt)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // advance one rising edge and settle
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      reset    = 1'b1;
      in_valid = 1'b1;
      inst     = 32'h00500093;
      pc       = 64'h1000;
      flush    = 1'b0;
      out_ready = 1'b1;

      // reset with an instruction offered: nothing captured
      step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_ill_cnt",   64'(ill_cnt),   64'd0);
      chk("rst_imm",       imm,            64'd0);
      chk("rst_rd_en",     64'(rd_en),     64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      step();
      chk("rst2_out_valid", 64'(out_valid), 64'd0);

      // ADDI x1,x0,5
      reset = 1'b0;
      step();
      chk("addi_valid",   64'(out_valid), 64'd1);
      chk("addi_rd_addr", 64'(rd_addr),   64'd1);
      chk("addi_rd_en",   64'(rd_en),     64'd1);
      chk("addi_ra_addr", 64'(ra_addr),   64'd0);
      chk("addi_ra_en",   64'(ra_en),     64'd1);
      chk("addi_rb_en",   64'(rb_en),     64'd0);
      chk("addi_imm",     imm,            64'd5);
      chk("addi_ctl",     64'(alu_ctl),   64'h0);
      chk("addi_bsrc",    64'(alu_bsrc),  64'd1);
      chk("addi_pc",      out_pc,         64'h1000);
      chk("addi_illegal", 64'(illegal),   64'd0);

      // SRAI x2,x1,3
      inst = 32'h4030D113; pc = 64'h1004;
      step();
      chk("srai_ctl",     64'(alu_ctl),  64'hD);
      chk("srai_imm",     imm,           64'd3);
      chk("srai_ra_addr", 64'(ra_addr),  64'd1);
      chk("srai_rd_addr", 64'(rd_addr),  64'd2);
      chk("srai_illegal", 64'(illegal),  64'd0);
      chk("srai_pc",      out_pc,        64'h1004);

      // ADDI x1,x0,-1: negative immediate sign extension
      inst = 32'hFFF00093; pc = 64'h1008;
      step();
      chk("addin_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);

      // ADDI x0,x0,5: legal but no writeback to x0
      inst = 32'h00500013;
      step();
      chk("x0_rd_en",   64'(rd_en),   64'd0);
      chk("x0_illegal", 64'(illegal), 64'd0);

      // SUB x1,x2,x3
      inst = 32'h403100B3;
      step();
      chk("sub_ctl",     64'(alu_ctl),  64'h8);
      chk("sub_rb_en",   64'(rb_en),    64'd1);
      chk("sub_rb_addr", 64'(rb_addr),  64'd3);
      chk("sub_ra_addr", 64'(ra_addr),  64'd2);
      chk("sub_bsrc",    64'(alu_bsrc), 64'd0);
      chk("sub_imm",     imm,           64'd0);

      // LUI x5,0x80000
      inst = 32'h800002B7; pc = 64'h1010;
      step();
      chk("lui_imm",     imm,           64'hFFFF_FFFF_8000_0000);
      chk("lui_ctl",     64'(alu_ctl),  64'hF);
      chk("lui_ra_en",   64'(ra_en),    64'd0);
      chk("lui_rd_addr", 64'(rd_addr),  64'd5);
      chk("lui_bsrc",    64'(alu_bsrc), 64'd1);

      // stall three cycles with AUIPC x6,0x1 waiting upstream
      inst = 32'h00001317; pc = 64'h1014; out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_imm",   imm,            64'hFFFF_FFFF_8000_0000);
         chk("stall_ctl",   64'(alu_ctl),   64'hF);
         chk("stall_ready", 64'(in_ready),  64'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("drain_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("auipc_valid", 64'(out_valid), 64'd1);
      chk("auipc_apc",   64'(alu_apc),   64'd1);
      chk("auipc_ctl",   64'(alu_ctl),   64'h0);
      chk("auipc_imm",   imm,            64'h1000);
      chk("auipc_rd",    64'(rd_addr),   64'd6);
      chk("auipc_pc",    out_pc,         64'h1014);

      // two all-ones illegal words
      inst = 32'hFFFFFFFF;
      step();
      chk("ill1_illegal", 64'(illegal), 64'd1);
      chk("ill1_cnt",     64'(ill_cnt), 64'd1);
      chk("ill1_rd_en",   64'(rd_en),   64'd0);
      chk("ill1_ra_en",   64'(ra_en),   64'd0);
      chk("ill1_imm",     imm,          64'd0);
      chk("ill1_apc",     64'(alu_apc), 64'd0);
      chk("ill1_rd_addr", 64'(rd_addr), 64'd31);
      step();
      chk("ill2_cnt", 64'(ill_cnt), 64'd2);

      // flush beats an incoming illegal instruction
      flush = 1'b1;
      step();
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_cnt",   64'(ill_cnt),   64'd2);
      flush = 1'b0;

      // SUB-form funct7 with SLL funct3 is illegal
      inst = 32'h403110B3;
      step();
      chk("badop_illegal", 64'(illegal), 64'd1);
      chk("badop_cnt",     64'(ill_cnt), 64'd3);
      chk("badop_rb_en",   64'(rb_en),   64'd0);

      // load and stall, then reset mid-stall
      inst = 32'h00500093; out_ready = 1'b0;
      step();
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      step();
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_cnt",   64'(ill_cnt),   64'd0);
      reset = 1'b0;

      // ADD x3,x1,x2 after reset
      inst = 32'h002081B3; pc = 64'h2000;
      step();
      chk("add_valid",   64'(out_valid), 64'd1);
      chk("add_rb_en",   64'(rb_en),     64'd1);
      chk("add_bsrc",    64'(alu_bsrc),  64'd0);
      chk("add_ctl",     64'(alu_ctl),   64'h0);
      chk("add_rd_addr", 64'(rd_addr),   64'd3);
      chk("add_rb_addr", 64'(rb_addr),   64'd2);

      // drain with no new instruction
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("idle_valid", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
